// File: rtl/commit_monitor.sv
// commit_monitor: watches the core's writeback port, republishes each retired
// instruction as a registered commit pulse, keeps a shadow GPR file, counts
// retired instructions and cycles, and halts on EBREAK or on a commit timeout.
//
// Handshake: wb_valid is a one-cycle retire strobe with no back-pressure. A
// retire is consumed (accept) only while the FSM is in RUN; in BREAK or HALT it
// is dropped without side effects. commit_valid is the registered echo of
// accept, asserted for exactly one cycle after the consuming edge, and the
// shadow registers and instret already reflect that retire while it is high.
module commit_monitor #(
  parameter int unsigned TIMEOUT     = 1000,
  parameter logic [31:0] EBREAK_INST = 32'h00100073
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [63:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_rf_wen,
  input  logic [4:0]  wb_rf_waddr,
  input  logic [63:0] wb_rf_wdata,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic [63:0] rf_0,  rf_1,  rf_2,  rf_3,  rf_4,  rf_5,  rf_6,  rf_7,
  output logic [63:0] rf_8,  rf_9,  rf_10, rf_11, rf_12, rf_13, rf_14, rf_15,
  output logic [63:0] rf_16, rf_17, rf_18, rf_19, rf_20, rf_21, rf_22, rf_23,
  output logic [63:0] rf_24, rf_25, rf_26, rf_27, rf_28, rf_29, rf_30, rf_31,
  output logic        is_break,
  output logic        halt,
  output logic        halt_timeout,
  output logic [63:0] halt_code,
  output logic [63:0] instret,
  output logic [63:0] cycles,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_BREAK = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic        commit_valid_q;
  logic [63:0] commit_pc_q;
  logic [31:0] commit_inst_q;
  logic [63:0] rf_q [32];
  logic        is_break_q;
  logic        halt_timeout_q;
  logic [63:0] halt_code_q;
  logic [63:0] instret_q;
  logic [63:0] cycles_q;
  logic [31:0] idle_q;

  logic        accept;
  logic        is_ebreak;
  logic        timeout_hit;
  logic        rf_write;

  assign accept      = (state_q == S_RUN) && wb_valid;
  assign is_ebreak   = (wb_inst == EBREAK_INST);
  // A commit on the final idle edge wins over the timeout.
  assign timeout_hit = (state_q == S_RUN) && !wb_valid && (idle_q == 32'(TIMEOUT - 1));
  // x0 is hardwired to zero, so writes to it are dropped here.
  assign rf_write    = accept && wb_rf_wen && (wb_rf_waddr != 5'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic: EBREAK detours through BREAK for one cycle, timeout goes straight to HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (accept && is_ebreak) state_d = S_BREAK;
        else if (timeout_hit)    state_d = S_HALT;
      end
      S_BREAK: state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    halt      = (state_q == S_HALT);
    dbg_state = state_q;
  end

  // Commit echo, shadow GPRs, halt bookkeeping and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_inst_q  <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      is_break_q     <= 1'b0;
      halt_timeout_q <= 1'b0;
      halt_code_q    <= '0;
      instret_q      <= '0;
      cycles_q       <= '0;
      idle_q         <= '0;
    end else begin
      commit_valid_q <= accept;
      if (accept) begin
        commit_pc_q   <= wb_pc;
        commit_inst_q <= wb_inst;
        instret_q     <= instret_q + 64'd1;
      end
      if (rf_write) rf_q[wb_rf_waddr] <= wb_rf_wdata;
      if (accept && is_ebreak) begin
        is_break_q <= 1'b1;
        // Capture a0 as it stands after this commit, including its own write.
        halt_code_q <= (wb_rf_wen && wb_rf_waddr == 5'd10) ? wb_rf_wdata : rf_q[10];
      end
      if (timeout_hit) halt_timeout_q <= 1'b1;
      if (state_q != S_HALT) cycles_q <= cycles_q + 64'd1;
      if (state_q == S_RUN) idle_q <= accept ? 32'd0 : idle_q + 32'd1;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign commit_inst  = commit_inst_q;
  assign is_break     = is_break_q;
  assign halt_timeout = halt_timeout_q;
  assign halt_code    = halt_code_q;
  assign instret      = instret_q;
  assign cycles       = cycles_q;

  assign rf_0  = rf_q[0];  assign rf_1  = rf_q[1];  assign rf_2  = rf_q[2];  assign rf_3  = rf_q[3];
  assign rf_4  = rf_q[4];  assign rf_5  = rf_q[5];  assign rf_6  = rf_q[6];  assign rf_7  = rf_q[7];
  assign rf_8  = rf_q[8];  assign rf_9  = rf_q[9];  assign rf_10 = rf_q[10]; assign rf_11 = rf_q[11];
  assign rf_12 = rf_q[12]; assign rf_13 = rf_q[13]; assign rf_14 = rf_q[14]; assign rf_15 = rf_q[15];
  assign rf_16 = rf_q[16]; assign rf_17 = rf_q[17]; assign rf_18 = rf_q[18]; assign rf_19 = rf_q[19];
  assign rf_20 = rf_q[20]; assign rf_21 = rf_q[21]; assign rf_22 = rf_q[22]; assign rf_23 = rf_q[23];
  assign rf_24 = rf_q[24]; assign rf_25 = rf_q[25]; assign rf_26 = rf_q[26]; assign rf_27 = rf_q[27];
  assign rf_28 = rf_q[28]; assign rf_29 = rf_q[29]; assign rf_30 = rf_q[30]; assign rf_31 = rf_q[31];

endmodule
